// File: rtl/hpdc_mem_rd_responder_pkg.sv
// Shared hpdcache memory-interface types and helpers for the read responder slice.
// Stands in for the request/response typedefs and error enum of the full cache package.
package hpdc_mem_rd_responder_pkg;

    localparam int HPDCACHE_PA_WIDTH       = 64;
    localparam int HPDCACHE_MEM_DATA_WIDTH = 512;
    localparam int HPDCACHE_MEM_ID_WIDTH   = 8;
    localparam int HPDCACHE_MEM_LEN_WIDTH  = 8;
    localparam int HPDCACHE_MEM_SIZE_WIDTH = 3;
    localparam int BEAT_BYTES              = HPDCACHE_MEM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_READ   = 2'b00,
        HPDCACHE_MEM_WRITE  = 2'b01,
        HPDCACHE_MEM_ATOMIC = 2'b10
    } hpdcache_mem_command_e;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_RESP_OK  = 2'b00,
        HPDCACHE_MEM_RESP_NOK = 2'b10
    } hpdcache_mem_error_e;

    typedef struct packed {
        logic [HPDCACHE_PA_WIDTH-1:0]       addr;
        logic [HPDCACHE_MEM_LEN_WIDTH-1:0]  len;
        logic [HPDCACHE_MEM_SIZE_WIDTH-1:0] size;
        logic [HPDCACHE_MEM_ID_WIDTH-1:0]   id;
        hpdcache_mem_command_e              command;
        logic [3:0]                         atomic;
        logic                               cacheable;
    } hpdcache_mem_req_t;

    typedef struct packed {
        hpdcache_mem_error_e                error;
        logic [HPDCACHE_MEM_ID_WIDTH-1:0]   id;
        logic [HPDCACHE_MEM_DATA_WIDTH-1:0] data;
        logic                               last;
    } hpdcache_mem_resp_r_t;

    // Line-aligned byte address of a given beat of a burst.
    function automatic logic [HPDCACHE_PA_WIDTH-1:0] beat_addr(
        input logic [HPDCACHE_PA_WIDTH-1:0]      addr,
        input logic [HPDCACHE_MEM_LEN_WIDTH-1:0] beat
    );
        return (addr & ~HPDCACHE_PA_WIDTH'(BEAT_BYTES - 1))
             + (HPDCACHE_PA_WIDTH'(beat) * HPDCACHE_PA_WIDTH'(BEAT_BYTES));
    endfunction

endpackage

// File: rtl/hpdc_req_fifo.sv
// Synchronous FIFO of memory read requests; head is visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module hpdc_req_fifo
    import hpdc_mem_rd_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  hpdcache_mem_req_t push_data,
    output logic              full,
    input  logic              pop,
    output hpdcache_mem_req_t head,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    hpdcache_mem_req_t  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hpdc_mem_rd_responder.sv
// Serves hpdcache memory read requests from a synchronous SRAM backing store, one 64 B beat per sram access.
// Optional macro HPDC_MEM_RANGE_CHECK_EN returns NOK beats for bursts outside [MEM_BASE, MEM_BASE+MEM_BYTES).
module hpdc_mem_rd_responder
    import hpdc_mem_rd_responder_pkg::*;
#(
    parameter int unsigned                  REQ_FIFO_DEPTH = 2,
    parameter logic [HPDCACHE_PA_WIDTH-1:0] MEM_BASE       = 64'h8000_0000,
    parameter logic [HPDCACHE_PA_WIDTH-1:0] MEM_BYTES      = 64'h10_0000
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               mem_req_valid_i,
    output logic                               mem_req_ready_o,
    input  hpdcache_mem_req_t                  mem_req_i,
    output logic                               mem_resp_r_valid_o,
    input  logic                               mem_resp_r_ready_i,
    output hpdcache_mem_resp_r_t               mem_resp_r_o,
    output logic                               sram_req_o,
    output logic [HPDCACHE_PA_WIDTH-1:0]       sram_addr_o,
    input  logic [HPDCACHE_MEM_DATA_WIDTH-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

`ifdef HPDC_MEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    state_e                              state_q, state_d;
    logic                                fifo_push, fifo_pop, fifo_full, fifo_empty;
    hpdcache_mem_req_t                   head;

    logic [HPDCACHE_PA_WIDTH-1:0]        cur_addr_q;
    logic [HPDCACHE_MEM_LEN_WIDTH-1:0]   len_q;
    logic [HPDCACHE_MEM_LEN_WIDTH-1:0]   beat_q;
    logic [HPDCACHE_MEM_ID_WIDTH-1:0]    id_q;
    logic                                nok_q;
    logic                                single_q;

    logic [HPDCACHE_PA_WIDTH-1:0]        first_addr, last_addr, mem_end;
    logic                                head_in_range, head_is_read, head_nok;
    logic                                resp_last, resp_hs;
    logic                                unused_req_fields;

    hpdc_req_fifo #(
        .DEPTH     (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (fifo_push),
        .push_data (mem_req_i),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .head      (head),
        .empty     (fifo_empty)
    );

    // Ready is gated by reset so no request is taken while the FIFO is being cleared.
    assign mem_req_ready_o = rstn_i && !fifo_full;
    assign fifo_push       = mem_req_valid_i && mem_req_ready_o;

    assign first_addr    = beat_addr(head.addr, '0);
    assign last_addr     = beat_addr(head.addr, head.len);
    assign mem_end       = MEM_BASE + MEM_BYTES;
    assign head_in_range = (first_addr >= MEM_BASE) && (first_addr < mem_end)
                        && (last_addr >= MEM_BASE) && (last_addr < mem_end);
    assign head_is_read  = (head.command == HPDCACHE_MEM_READ);
    assign head_nok      = !head_is_read || (RANGE_CHECK_EN && !head_in_range);

    // Data selection always returns full beats, so these request fields are intentionally ignored.
    assign unused_req_fields = ^{head.size, head.atomic, head.cacheable};

    assign resp_last = single_q || (beat_q == len_q);
    assign resp_hs   = mem_resp_r_valid_o && mem_resp_r_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d            = state_q;
        fifo_pop           = 1'b0;
        sram_req_o         = 1'b0;
        sram_addr_o        = '0;
        mem_resp_r_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = head_nok ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                sram_req_o  = 1'b1;
                sram_addr_o = beat_addr(cur_addr_q, beat_q);
                state_d     = RESP;
            end
            RESP: begin
                mem_resp_r_valid_o = 1'b1;
                if (mem_resp_r_ready_i) begin
                    if (resp_last) state_d = IDLE;
                    else           state_d = nok_q ? RESP : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_addr_q <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            id_q       <= '0;
            nok_q      <= 1'b0;
            single_q   <= 1'b0;
        end else if (fifo_pop) begin
            cur_addr_q <= head.addr;
            len_q      <= head.len;
            beat_q     <= '0;
            id_q       <= head.id;
            nok_q      <= head_nok;
            single_q   <= !head_is_read;
        end else if (resp_hs && !resp_last) begin
            beat_q     <= beat_q + HPDCACHE_MEM_LEN_WIDTH'(1);
        end
    end

    // Read data passes straight through: the sram holds it stable until the next sram_req_o.
    assign mem_resp_r_o = '{
        error: nok_q ? HPDCACHE_MEM_RESP_NOK : HPDCACHE_MEM_RESP_OK,
        id:    id_q,
        data:  nok_q ? '0 : sram_rdata_i,
        last:  resp_last
    };

endmodule
